// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: RV32M funct3 op codes
// and the control FSM state encoding.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } mdu_op_t;

  // op[2] selects the divide family; within it op[1] selects remainder, op[0] unsigned.
  localparam int unsigned MDU_DIV_BIT = 2;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } mdu_state_t;

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, XLEN cycles after start.
// done stays high until the next start or kill.
module mdu_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic [XLEN-1:0] quo_q, rem_q, dsr_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, done_q;
  logic [XLEN:0]   part, diff;

  // Partial remainder needs one extra bit: shifted value can reach 2*divisor-1.
  always_comb begin
    part = {rem_q, quo_q[XLEN-1]};
    diff = part - {1'b0, dsr_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (kill) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dsr_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      if (diff[XLEN]) begin
        rem_q <= part[XLEN-1:0];
      end else begin
        rem_q <= diff[XLEN-1:0];
      end
      quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
      cnt_q <= cnt_q + CntW'(1);
      if (cnt_q == CntW'(XLEN - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response channels.
// Owns sign handling, divide special cases, the multiplier and the control FSM.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int unsigned CntW = $clog2(MUL_LATENCY + 1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t       state_q;
  mdu_op_t          op_q;
  logic [XLEN-1:0]  rs1_q, rs2_q, result_q;
  logic [TAG_W-1:0] tag_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_q, valid_q;

  logic            accept, is_div, is_rem, op_signed, rs1_neg, rs2_neg;
  logic            div_zero, div_ovf, div_start, div_done;
  logic [XLEN-1:0] abs1, abs2, special_res, div_quo, div_rem, fix_res, mul_res;
  logic            a_sgn, b_sgn;
  logic [2*XLEN-1:0] prod;

  assign req_ready = (state_q == StIdle) & ~kill & ~rst;
  assign accept    = req_valid & req_ready;

  always_comb begin
    is_div      = req_op[MDU_DIV_BIT];
    is_rem      = req_op[1];
    op_signed   = ~req_op[0];
    rs1_neg     = op_signed & req_rs1[XLEN-1];
    rs2_neg     = op_signed & req_rs2[XLEN-1];
    abs1        = rs1_neg ? -req_rs1 : req_rs1;
    abs2        = rs2_neg ? -req_rs2 : req_rs2;
    div_zero    = (req_rs2 == '0);
    div_ovf     = op_signed & (req_rs1 == MinInt) & (req_rs2 == '1);
    div_start   = accept & is_div & ~div_zero & ~div_ovf;
    special_res = div_zero ? (is_rem ? req_rs1 : '1) : (is_rem ? '0 : req_rs1);
  end

  // Operands are sign-extended to 2*XLEN so an unsigned multiply yields the exact product.
  always_comb begin
    a_sgn   = rs1_q[XLEN-1] & ((op_q == OpMulh) | (op_q == OpMulhsu));
    b_sgn   = rs2_q[XLEN-1] & (op_q == OpMulh);
    prod    = {{XLEN{a_sgn}}, rs1_q} * {{XLEN{b_sgn}}, rs2_q};
    mul_res = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    fix_res = op_q[1] ? (neg_q ? -div_rem : div_rem) : (neg_q ? -div_quo : div_quo);
  end

  mdu_divider #(
    .XLEN(XLEN)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .kill     (kill),
    .start    (div_start),
    .dividend (abs1),
    .divisor  (abs2),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else if (kill) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q  <= mdu_op_t'(req_op);
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            tag_q <= req_tag;
            cnt_q <= '0;
            neg_q <= is_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
            if (!is_div) begin
              state_q <= StMul;
            end else if (div_zero || div_ovf) begin
              // Response is raised one cycle later from DONE.
              result_q <= special_res;
              state_q  <= StDone;
            end else begin
              state_q <= StDiv;
            end
          end
        end
        StMul: begin
          if (cnt_q == CntW'(MUL_LATENCY - 1)) begin
            result_q <= mul_res;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDiv: begin
          if (div_done) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (resp_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid  = valid_q;
  assign resp_result = result_q;
  assign resp_tag    = tag_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: table of directed vectors plus handshake, kill and reset sequences.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst, kill, req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1, req_rs2, resp_result;
  logic [4:0]  req_tag, resp_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  mdu #(
    .XLEN       (32),
    .MUL_LATENCY(2),
    .TAG_W      (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kill       (kill),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_tag   (resp_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one request, measure edges from accept to resp_valid, check result/tag, then take it.
  task automatic run_vec(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp, input int lat);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) break;
    end
    chk({nm, " latency"}, k, lat);
    chk({nm, " result"}, resp_result, exp);
    chk({nm, " tag"}, {27'd0, resp_tag}, {27'd0, tag});
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"mul 7*-3",        3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 2};
    vecs[1]  = '{"mulh min*min",    3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 2};
    vecs[2]  = '{"mulhsu -1*ffff",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 2};
    vecs[3]  = '{"mulhu ffff*ffff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 2};
    vecs[4]  = '{"mul ffff*ffff",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000001, 2};
    vecs[5]  = '{"div -7/2",        3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 34};
    vecs[6]  = '{"rem -7/2",        3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 34};
    vecs[7]  = '{"divu fffe/2",     3'd5, 32'hFFFFFFFE, 32'd2,        5'd8,  32'h7FFFFFFF, 34};
    vecs[8]  = '{"remu 100/7",      3'd7, 32'd100,      32'd7,        5'd9,  32'd2,        34};
    vecs[9]  = '{"div 7/-2",        3'd4, 32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 34};
    vecs[10] = '{"rem 7/-2",        3'd6, 32'd7,        32'hFFFFFFFE, 5'd11, 32'd1,        34};
    vecs[11] = '{"div 5/0",         3'd4, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1};
    vecs[12] = '{"divu 5/0",        3'd5, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
    vecs[13] = '{"rem 5/0",         3'd6, 32'd5,        32'd0,        5'd14, 32'd5,        1};
    vecs[14] = '{"remu 5/0",        3'd7, 32'd5,        32'd0,        5'd15, 32'd5,        1};
    vecs[15] = '{"div min/-1",      3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1};
    vecs[16] = '{"rem min/-1",      3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1};
    vecs[17] = '{"divu min/ffff",   3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        34};
    vecs[18] = '{"remu min/ffff",   3'd7, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 34};
    vecs[19] = '{"mulhsu -2*3",     3'd2, 32'hFFFFFFFE, 32'd3,        5'd20, 32'hFFFFFFFF, 2};

    rst = 1'b1; kill = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'd0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    #12;
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_result", resp_result, 32'd0);
    chk("reset resp_tag", {27'd0, resp_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release req_ready", {31'd0, req_ready}, 32'd1);

    // kill in IDLE blocks acceptance
    req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd2; req_rs2 = 32'd2; kill = 1'b1;
    #1 chk("kill idle req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 begin req_valid = 1'b0; kill = 1'b0; end
    @(negedge clk);
    chk("kill idle stays idle", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 20; i++) begin
      run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
              vecs[i].lat);
    end

    // Backpressure: hold response for 10 cycles
    req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd3; req_rs2 = 32'd5; req_tag = 5'h1A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 10 && !resp_valid; k++) @(negedge clk);
    chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp held result", resp_result, 32'd15);
      chk("bp held tag", {27'd0, resp_tag}, 32'h1A);
      chk("bp held req_ready", {30'd0, req_ready, resp_valid}, 32'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp after take req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp after take resp_valid", {31'd0, resp_valid}, 32'd0);

    // kill during a divide
    req_valid = 1'b1; req_op = 3'd5; req_rs1 = 32'd100; req_rs2 = 32'd7; req_tag = 5'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill div req_ready", {31'd0, req_ready}, 32'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      chk("kill div no response", seen, 0);
    end
    run_vec("mul 3*4 after kill", 3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 2);

    // kill together with resp_ready in DONE discards the response
    req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd6; req_rs2 = 32'd6; req_tag = 5'd21;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 10 && !resp_valid; k++) @(negedge clk);
    chk("kill done result", resp_result, 32'd36);
    kill = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1 begin kill = 1'b0; resp_ready = 1'b0; end
    @(negedge clk);
    chk("kill done resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("kill done req_ready", {31'd0, req_ready}, 32'd1);

    // reset in the middle of a divide
    req_valid = 1'b1; req_op = 3'd5; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_tag = 5'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst mid req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst mid resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst mid resp_result", resp_result, 32'd0);
    chk("rst mid resp_tag", {27'd0, resp_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec("divu 9/3 after rst", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
